// File: rtl/router_vc_output_buffer.sv
// -----------------------------------------------------------------------------
// router_vc_output_buffer
//
// Output channel of a mesh router. NUM_VC virtual channels each own a
// VC_DEPTH-entry FIFO. Flits come in from the crossbar. At most one flit per
// cycle is drained to the inter-router link when the downstream is ready.
// Emptiness comes from the per-VC occupancy counters, so an all-zero flit is a
// normal payload.
//
// Optional feature (compile-time macro OCH_POLARITY_EN):
//   defined   - VC i may drain only when i[0] == polarity (even VCs on
//               polarity=0, odd VCs on polarity=1). Round-robin runs over that
//               subset, and the rr_ptr update rule does not change.
//   undefined - polarity is ignored, and every non-empty VC is eligible.
//
// Handshake semantics:
//   Input side : a flit is taken at a posedge when in_valid=1. It is written
//                only if the target VC was not full before that edge. in_ready
//                reports that state, and a push to a full VC is dropped and
//                sets the sticky overflow flag. in_ready does not gate
//                in_valid.
//   Output side: out_ready is sampled at the posedge. If it is high and some
//                VC is eligible, one flit is popped and shown for exactly one
//                cycle on out_valid/out_vc/out_data. There is no hold: the
//                downstream must take it. out_data is zero whenever
//                out_valid=0.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   polarity        router cycle polarity (used only with OCH_POLARITY_EN)
//   in_valid/in_vc/in_data   flit offered by the crossbar
//   in_ready        per-VC "not full", from registered state
//   vc_blocked      per-VC "has data but out_ready is low" (combinational)
//   out_ready       downstream accepts a flit this cycle
//   out_valid/out_vc/out_data  registered output flit, one-cycle pulse
//   overflow        sticky flag: a push to a full VC was dropped
// -----------------------------------------------------------------------------
module router_vc_output_buffer #(
    parameter int DATA_W   = 64,
    parameter int NUM_VC   = 2,
    parameter int VC_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       polarity,
    input  logic                       in_valid,
    input  logic [$clog2(NUM_VC)-1:0]  in_vc,
    input  logic [DATA_W-1:0]          in_data,
    output logic [NUM_VC-1:0]          in_ready,
    output logic [NUM_VC-1:0]          vc_blocked,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [$clog2(NUM_VC)-1:0]  out_vc,
    output logic [DATA_W-1:0]          out_data,
    output logic                       overflow
);

    localparam int VC_W  = $clog2(NUM_VC);
    localparam int CNT_W = $clog2(VC_DEPTH + 1);
    localparam int PTR_W = $clog2(VC_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(VC_DEPTH);

    logic [DATA_W-1:0] mem    [NUM_VC][VC_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [CNT_W-1:0]  count  [NUM_VC];
    logic [VC_W-1:0]   rr_ptr;

    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] push_ok;
    logic [NUM_VC-1:0] pop_ok;
    logic              any_elig;
    logic [VC_W-1:0]   winner;
    logic [VC_W-1:0]   cand;
    logic [DATA_W-1:0] head_data;

`ifndef OCH_POLARITY_EN
    // polarity has no effect in this build.
    logic unused_polarity;
    assign unused_polarity = polarity;
`endif

    // Per-VC status. All of it comes from the pre-edge count, so a full VC
    // refuses a push even when it pops in the same cycle.
    always_comb begin
        in_ready   = '0;
        vc_blocked = '0;
        eligible   = '0;
        push_ok    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            in_ready[i]   = (count[i] != FULL_CNT);
            vc_blocked[i] = (count[i] != '0) && !out_ready;
`ifdef OCH_POLARITY_EN
            eligible[i]   = (count[i] != '0) && (((i % 2) == 1) == polarity);
`else
            eligible[i]   = (count[i] != '0);
`endif
            push_ok[i]    = in_valid && (in_vc == VC_W'(i)) && (count[i] != FULL_CNT);
        end
    end

    // Round-robin search from rr_ptr. NUM_VC is a power of two, so the VC_W-bit
    // add wraps modulo NUM_VC.
    always_comb begin
        any_elig = 1'b0;
        winner   = '0;
        cand     = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            cand = rr_ptr + VC_W'(k);
            if (!any_elig && eligible[cand]) begin
                any_elig = 1'b1;
                winner   = cand;
            end
        end
    end

    always_comb begin
        pop_ok = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            pop_ok[i] = out_ready && any_elig && (winner == VC_W'(i));
        end
    end

    assign head_data = mem[winner][rd_ptr[winner]];

    // Flit storage is not reset. The counters alone say which entries hold
    // data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_VC; i++) begin
            if (!reset && push_ok[i]) begin
                mem[i][wr_ptr[i]] <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_vc    <= '0;
            out_data  <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < NUM_VC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                // VC_DEPTH is a power of two, so the pointers wrap by themselves.
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop_ok[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CNT_W'(push_ok[i]) - CNT_W'(pop_ok[i]);
            end

            if (in_valid && (count[in_vc] == FULL_CNT)) begin
                overflow <= 1'b1;
            end

            if (out_ready && any_elig) begin
                out_valid <= 1'b1;
                out_vc    <= winner;
                out_data  <= head_data;
                rr_ptr    <= winner + 1'b1;
            end else begin
                out_valid <= 1'b0;
                out_vc    <= '0;
                out_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_router_vc_output_buffer.sv
module tb_router_vc_output_buffer;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        in_valid;
    logic [0:0]  in_vc;
    logic [63:0] in_data;
    logic [1:0]  in_ready;
    logic [1:0]  vc_blocked;
    logic        out_ready;
    logic        out_valid;
    logic [0:0]  out_vc;
    logic [63:0] out_data;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    // scoreboard: {vc, data} expected in drain order
    logic [64:0] exp_q[$];
    logic [64:0] exp_e;

    always #5 clk = ~clk;

    router_vc_output_buffer #(.DATA_W(64), .NUM_VC(2), .VC_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data),
        .in_ready(in_ready), .vc_blocked(vc_blocked),
        .out_ready(out_ready), .out_valid(out_valid), .out_vc(out_vc),
        .out_data(out_data), .overflow(overflow)
    );

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Advance one posedge, then settle 1 time unit so outputs are sampled away
    // from the edge and new inputs are set up for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [0:0] vc, input logic [63:0] d);
        in_valid = 1'b1;
        in_vc    = vc;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; polarity = 1'b0;
        in_valid = 1'b1; in_vc = 1'b1; in_data = 64'hDEAD_BEEF_0BAD_F00D;
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (out_vc !== 1'b0) begin bad++; $display("FAIL reset_out_vc got=%0d exp=0", out_vc); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (in_ready !== 2'b11) begin bad++; $display("FAIL reset_in_ready got=%b exp=11", in_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        total++; if (vc_blocked !== 2'b00) begin bad++; $display("FAIL reset_vc_blocked got=%b exp=00", vc_blocked); end
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_vc = '0;
    endtask

    task automatic test_single_flit();
        out_ready = 1'b1;
        drive_push(1'b1, 64'h0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0b exp=0", out_valid); end
        tick();
        total++; if ({out_valid, out_vc, out_data} !== {1'b1, 1'b1, 64'h0}) begin
            bad++; $display("FAIL single_out got=%0b/%0d/%h exp=1/1/0", out_valid, out_vc, out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%0b exp=0", out_valid); end
    endtask

    task automatic test_fill_overflow();
        logic [63:0] vals [5];
        vals[0] = 64'h1111; vals[1] = 64'h2222; vals[2] = 64'h3333;
        vals[3] = 64'h4444; vals[4] = 64'h5555;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_push(1'b0, vals[k]);
            if (k < 4) exp_q.push_back({1'b0, vals[k]});
            if (k == 2) begin
                total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL fill_ready3 got=%0b exp=1", in_ready[0]); end
            end
            if (k == 3) begin
                total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL fill_ready4 got=%0b exp=0", in_ready[0]); end
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got=%0b exp=0", overflow); end
            end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%0b exp=1", overflow); end
        total++; if (vc_blocked !== 2'b01) begin bad++; $display("FAIL fill_blocked got=%b exp=01", vc_blocked); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_no_out got=%0b exp=0", out_valid); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_e = exp_q.pop_front();
            total++; if ({out_valid, out_vc, out_data} !== {1'b1, exp_e}) begin
                bad++; $display("FAIL fill_drain%0d got=%0b/%0d/%h exp=1/%0d/%h", k, out_valid, out_vc, out_data, exp_e[64], exp_e[63:0]); end
        end
        tick();
        total++; if ({out_valid, out_data} !== {1'b0, 64'h0}) begin
            bad++; $display("FAIL fill_empty got=%0b/%h exp=0/0", out_valid, out_data); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_sticky got=%0b exp=1", overflow); end
        total++; if (in_ready !== 2'b11) begin bad++; $display("FAIL fill_ready_back got=%b exp=11", in_ready); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive_push(1'b1, 64'hAAAA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mreset_overflow got=%0b exp=0", overflow); end
        total++; if (vc_blocked !== 2'b00) begin bad++; $display("FAIL mreset_blocked got=%b exp=00", vc_blocked); end
        // first push right after reset release must be taken
        out_ready = 1'b1;
        drive_push(1'b1, 64'h0123_4567_89AB_CDEF);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mreset_discard got=%0b exp=0", out_valid); end
        tick();
        total++; if ({out_valid, out_vc, out_data} !== {1'b1, 1'b1, 64'h0123_4567_89AB_CDEF}) begin
            bad++; $display("FAIL mreset_first got=%0b/%0d/%h exp=1/1/0123456789abcdef", out_valid, out_vc, out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mreset_tail got=%0b exp=0", out_valid); end
    endtask

    task automatic test_round_robin();
        out_ready = 1'b0;
        drive_push(1'b0, 64'hA); exp_q.push_back({1'b0, 64'hA});
        drive_push(1'b1, 64'hC);
        drive_push(1'b0, 64'hB);
        drive_push(1'b1, 64'hD);
        exp_q.push_back({1'b1, 64'hC});
        exp_q.push_back({1'b0, 64'hB});
        exp_q.push_back({1'b1, 64'hD});
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_e = exp_q.pop_front();
            total++; if ({out_valid, out_vc, out_data} !== {1'b1, exp_e}) begin
                bad++; $display("FAIL rr_%0d got=%0b/%0d/%h exp=1/%0d/%h", k, out_valid, out_vc, out_data, exp_e[64], exp_e[63:0]); end
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_idle got=%0b exp=0", out_valid); end
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0;
        drive_push(1'b0, 64'hE);
        drive_push(1'b0, 64'hF);
        // push G while popping E
        in_valid = 1'b1; in_vc = 1'b0; in_data = 64'h1A; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if ({out_valid, out_vc, out_data} !== {1'b1, 1'b0, 64'hE}) begin
            bad++; $display("FAIL pp_pop got=%0b/%0d/%h exp=1/0/e", out_valid, out_vc, out_data); end
        drive_push(1'b0, 64'h2B);
        total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL pp_count3 got=%0b exp=1", in_ready[0]); end
        drive_push(1'b0, 64'h3C);
        total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL pp_count4 got=%0b exp=0", in_ready[0]); end
        exp_q.push_back({1'b0, 64'hF});
        exp_q.push_back({1'b0, 64'h1A});
        exp_q.push_back({1'b0, 64'h2B});
        exp_q.push_back({1'b0, 64'h3C});
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_e = exp_q.pop_front();
            total++; if ({out_valid, out_vc, out_data} !== {1'b1, exp_e}) begin
                bad++; $display("FAIL pp_drain%0d got=%0b/%0d/%h exp=1/%0d/%h", k, out_valid, out_vc, out_data, exp_e[64], exp_e[63:0]); end
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pp_idle got=%0b exp=0", out_valid); end
    endtask

    task automatic test_polarity();
        out_ready = 1'b0;
        drive_push(1'b0, 64'h4D);
        drive_push(1'b1, 64'h5E);
        polarity = 1'b1; out_ready = 1'b1;
        tick();
        // rr_ptr is 1 after the VC0-only drain above
        total++; if ({out_valid, out_vc, out_data} !== {1'b1, 1'b1, 64'h5E}) begin
            bad++; $display("FAIL pol_first got=%0b/%0d/%h exp=1/1/5e", out_valid, out_vc, out_data); end
`ifdef OCH_POLARITY_EN
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pol_hold got=%0b exp=0", out_valid); end
        polarity = 1'b0;
`endif
        tick();
        total++; if ({out_valid, out_vc, out_data} !== {1'b1, 1'b0, 64'h4D}) begin
            bad++; $display("FAIL pol_second got=%0b/%0d/%h exp=1/0/4d", out_valid, out_vc, out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pol_idle got=%0b exp=0", out_valid); end
        polarity = 1'b0;
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        test_reset();
        test_single_flit();
        test_fill_overflow();
        test_mid_reset();
        test_round_robin();
        test_push_pop();
        test_polarity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
